// File: rtl/wb_dma_copy_if.sv
// wb_dma_copy_if: config-slave and copy-master Wishbone signals of wb_dma_copy
interface wb_dma_copy_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_address;
  logic [31:0] o_wb_data;
  logic [31:0] i_wb_data;
  logic        i_wb_ack;
  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i, i_wb_data, i_wb_ack,
    output wb_dat_o, wb_ack_o, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_address, o_wb_data
  );
  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i, i_wb_data, i_wb_ack,
    input  wb_dat_o, wb_ack_o, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_address, o_wb_data
  );
endinterface

// File: rtl/wb_dma_copy.sv
// wb_dma_copy: word-by-word Wishbone memory copy engine; define DMA_IRQ_EN for the irq output and CTRL bit3 IRQ_ENABLE
module wb_dma_copy #(
  parameter int LEN_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  wb_dma_copy_if.slave bus
`ifdef DMA_IRQ_EN
  ,
  output logic irq
`endif
);
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
  state_t state, state_n;
  logic [31:0] src, dst, buf_q, rd_data;
  logic [LEN_WIDTH-1:0] len;
  logic [1:0] a;
  logic done, done_n, err, abort_q, irq_en;
  logic busy, acc, wr_acc, cfg_wr, wr_ctrl, go, misalign, abort_now, step, last;
  logic unused_ok;
  assign unused_ok = ^{bus.wb_sel_i, bus.wb_adr_i[31:4], bus.wb_adr_i[1:0]};
  assign a = bus.wb_adr_i[3:2];
  assign busy = state == RD || state == WR;
  assign acc = bus.wb_stb_i && bus.wb_cyc_i && !bus.wb_ack_o;
  assign wr_acc = acc && bus.wb_we_i;
  assign cfg_wr = wr_acc && !busy;
  assign wr_ctrl = wr_acc && a == 2'd3;
  assign go = wr_ctrl && bus.wb_dat_i[0] && !busy;
  assign misalign = |src[1:0] || |dst[1:0];
  assign abort_now = abort_q || (wr_ctrl && bus.wb_dat_i[2]);
  assign step = state == WR && bus.i_wb_ack;
  assign last = len == LEN_WIDTH'(1);
  // a FIN-set DONE outranks a same-cycle W1C clear
  assign done_n = state == FIN || (done && !(wr_ctrl && bus.wb_dat_i[1]));
  always_comb begin
    state_n = go ? ((misalign || len == '0) ? FIN : RD) :
              state == FIN ? IDLE :
              !(busy && bus.i_wb_ack) ? state :
              state == RD ? (abort_now ? FIN : WR) :
              (last || abort_now) ? FIN : RD;
    rd_data = a == 2'd0 ? src :
              a == 2'd1 ? dst :
              a == 2'd2 ? 32'(len) :
              {28'd0, irq_en, err, done, busy};
  end
  assign bus.o_wb_cyc = busy;
  assign bus.o_wb_stb = busy;
  assign bus.o_wb_we = state == WR;
  assign bus.o_wb_sel = busy ? 4'hF : 4'h0;
  assign bus.o_wb_address = state == WR ? dst : state == RD ? src : '0;
  assign bus.o_wb_data = state == WR ? buf_q : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      len <= '0;
      buf_q <= '0;
      done <= 1'b0;
      err <= 1'b0;
      abort_q <= 1'b0;
      bus.wb_ack_o <= 1'b0;
      bus.wb_dat_o <= '0;
    end else begin
      state <= state_n;
      bus.wb_ack_o <= acc;
      bus.wb_dat_o <= (acc && !bus.wb_we_i) ? rd_data : '0;
      buf_q <= (state == RD && bus.i_wb_ack) ? bus.i_wb_data : buf_q;
      src <= step ? src + 32'd4 : (cfg_wr && a == 2'd0) ? bus.wb_dat_i : src;
      dst <= step ? dst + 32'd4 : (cfg_wr && a == 2'd1) ? bus.wb_dat_i : dst;
      len <= step ? len - LEN_WIDTH'(1) : (cfg_wr && a == 2'd2) ? bus.wb_dat_i[LEN_WIDTH-1:0] : len;
      done <= done_n;
      err <= go ? misalign : err;
      abort_q <= busy && abort_now;
    end
  end
`ifdef DMA_IRQ_EN
  logic irq_en_n;
  assign irq_en_n = wr_ctrl ? bus.wb_dat_i[3] : irq_en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      irq_en <= irq_en_n;
      irq <= done_n && irq_en_n;
    end
  end
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: directed register vectors plus copy, abort, alignment and reset sequences against a slave memory
module tb_wb_dma_copy;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wb_dma_copy_if bus ();
`ifdef DMA_IRQ_EN
  logic irq;
  localparam logic [31:0] IRQ_BIT = 32'h8;
`else
  localparam logic [31:0] IRQ_BIT = 32'h0;
`endif
  wb_dma_copy dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef DMA_IRQ_EN
    ,
    .irq(irq)
`endif
  );
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int dly = 0;
  int cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int cyc_cnt = 0;
  int sel_bad = 0;
  logic [31:0] we_log = '0;
  logic [31:0] mem [0:1023];

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.i_wb_ack <= 1'b0;
      bus.i_wb_data <= '0;
      cnt <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else begin
      cyc_cnt <= cyc_cnt + (bus.o_wb_cyc ? 1 : 0);
      if ((bus.o_wb_stb && bus.o_wb_sel != 4'hF) || (!bus.o_wb_cyc && bus.o_wb_sel != 4'h0)) sel_bad <= sel_bad + 1;
      if (bus.i_wb_ack) bus.i_wb_ack <= 1'b0;
      else if (bus.o_wb_cyc && bus.o_wb_stb) begin
        if (cnt >= dly) begin
          bus.i_wb_ack <= 1'b1;
          cnt <= 0;
          we_log <= {we_log[30:0], bus.o_wb_we};
          if (bus.o_wb_we) begin
            mem[bus.o_wb_address[11:2]] <= bus.o_wb_data;
            wr_cnt <= wr_cnt + 1;
          end else begin
            bus.i_wb_data <= mem[bus.o_wb_address[11:2]];
            rd_cnt <= rd_cnt + 1;
          end
        end else cnt <= cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic we, input logic [31:0] adr, input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = wd;
    @(negedge clk);
    rd = bus.wb_dat_o;
    if (!bus.wb_ack_o) begin
      n_vec++;
      n_bad++;
      $display("FAIL cfg_ack adr %h: got 0 expected 1", adr);
    end
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] r;
    cfg(1'b1, adr, wd, r);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] r);
    cfg(1'b0, adr, 32'h0, r);
  endtask

  task automatic wait_done(input string name);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 200 && !r[1]; i++) rd(32'hC, r);
    check(name, {31'd0, r[1]}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[$];

  initial begin
    logic [31:0] r;
    logic [2:0] acks;
    int c0, b_rd, b_wr, nw;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    vt.push_back('{1'b0, 32'h0, 32'h0, 32'h0});
    vt.push_back('{1'b0, 32'h4, 32'h0, 32'h0});
    vt.push_back('{1'b0, 32'h8, 32'h0, 32'h0});
    vt.push_back('{1'b0, 32'hC, 32'h0, 32'h0});
    vt.push_back('{1'b1, 32'h0, 32'h1234_5678, 32'h0});
    vt.push_back('{1'b0, 32'h0, 32'h0, 32'h1234_5678});
    vt.push_back('{1'b1, 32'h4, 32'hDEAD_BEEC, 32'h0});
    vt.push_back('{1'b0, 32'h4, 32'h0, 32'hDEAD_BEEC});
    vt.push_back('{1'b1, 32'h8, 32'hFFFF_ABCD, 32'h0});
    vt.push_back('{1'b0, 32'h8, 32'h0, 32'h0000_ABCD});
    vt.push_back('{1'b1, 32'hC, 32'h8, 32'h0});
    vt.push_back('{1'b0, 32'hC, 32'h0, IRQ_BIT});
    vt.push_back('{1'b1, 32'hC, 32'h0, 32'h0});
    vt.push_back('{1'b0, 32'hC, 32'h0, 32'h0});
    vt.push_back('{1'b0, 32'h10, 32'h0, 32'h1234_5678});
    vt.push_back('{1'b0, 32'h18, 32'h0, 32'h0000_ABCD});
    repeat (3) @(negedge clk);
    check("reset_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
    check("reset_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    rst_n = 1'b1;
    foreach (vt[i]) begin
      if (vt[i].we) wr(vt[i].adr, vt[i].data);
      else begin
        rd(vt[i].adr, r);
        check($sformatf("vec%0d_adr%h", i, vt[i].adr), r, vt[i].exp);
      end
    end

    @(negedge clk);
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_adr_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acks[2-i] = bus.wb_ack_o;
    end
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    check("held_stb_ack_pattern", {29'd0, acks}, 32'd5);

    wr(32'h0, 32'h100);
    wr(32'h4, 32'h200);
    wr(32'h8, 32'd3);
    wr(32'hC, 32'h1);
    rd(32'hC, r);
    check("copy_busy", r & 32'h3, 32'h1);
    wr(32'h0, 32'h999);
    wait_done("copy_done");
    rd(32'hC, r);
    check("copy_stat", r, 32'h2);
    rd(32'h8, r);
    check("copy_len", r, 32'h0);
    rd(32'h0, r);
    check("copy_src", r, 32'h10C);
    rd(32'h4, r);
    check("copy_dst", r, 32'h20C);
    for (int i = 0; i < 3; i++) check($sformatf("copy_mem%0d", i), mem[32'h80 + i], pat(32'h40 + i));
    check("copy_xfers", rd_cnt + wr_cnt, 32'd6);
    check("copy_order", {26'd0, we_log[5:0]}, 32'h15);
    wr(32'hC, 32'h2);
    rd(32'hC, r);
    check("w1c_done", r, 32'h0);

    wr(32'h8, 32'h0);
    c0 = cyc_cnt;
    wr(32'hC, 32'h1);
    wait_done("len0_done");
    check("len0_no_cyc", cyc_cnt - c0, 32'd0);
    rd(32'hC, r);
    check("len0_stat", r, 32'h2);

    wr(32'hC, 32'h2);
    wr(32'h0, 32'h102);
    wr(32'h8, 32'h1);
    c0 = cyc_cnt;
    wr(32'hC, 32'h1);
    wait_done("align_done");
    rd(32'hC, r);
    check("align_stat", r, 32'h6);
    check("align_no_cyc", cyc_cnt - c0, 32'd0);

    wr(32'h0, 32'h100);
    wr(32'h4, 32'h300);
    wr(32'hC, 32'h3);
    rd(32'hC, r);
    check("start_clr_stat", r, 32'h1);
    wait_done("start_clr_done");
    rd(32'hC, r);
    check("start_clr_final", r, 32'h2);
    check("start_clr_mem", mem[32'hC0], pat(32'h40));

    wr(32'hC, 32'h2);
    dly = 5;
    wr(32'h0, 32'h100);
    wr(32'h4, 32'h400);
    wr(32'h8, 32'd8);
    b_rd = rd_cnt;
    b_wr = wr_cnt;
    wr(32'hC, 32'h1);
    for (int i = 0; i < 1000 && wr_cnt - b_wr < 2; i++) @(negedge clk);
    check("abort_wait_2wr", wr_cnt - b_wr, 32'd2);
    wr(32'hC, 32'h4);
    wait_done("abort_done");
    nw = wr_cnt - b_wr;
    check("abort_nw_range", {31'd0, nw == 2 || nw == 3}, 32'd1);
    check("abort_inflight_rd", {31'd0, (rd_cnt - b_rd) == nw || (rd_cnt - b_rd) == nw + 1}, 32'd1);
    rd(32'h8, r);
    check("abort_len", r, 32'd8 - nw);
    rd(32'h0, r);
    check("abort_src", r, 32'h100 + 4 * nw);
    for (int i = 0; i < nw; i++) check($sformatf("abort_mem%0d", i), mem[32'h100 + i], pat(32'h40 + i));

    wr(32'hC, 32'h2);
    wr(32'h4, 32'h500);
    wr(32'h8, 32'd4);
    wr(32'hC, 32'h1);
    for (int i = 0; i < 200 && !(bus.o_wb_stb && !bus.o_wb_we); i++) @(negedge clk);
    check("rst_seen_rd", {31'd0, bus.o_wb_stb && !bus.o_wb_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
    check("rst_async_stb", {31'd0, bus.o_wb_stb}, 32'd0);
    check("rst_async_sel", {28'd0, bus.o_wb_sel}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dly = 0;
    for (int i = 0; i < 4; i++) begin
      rd(32'(4 * i), r);
      check($sformatf("rst_reg%0d", i), r, 32'h0);
    end

`ifdef DMA_IRQ_EN
    wr(32'hC, 32'h8);
    wr(32'h0, 32'h100);
    wr(32'h4, 32'h600);
    wr(32'h8, 32'd1);
    check("irq_idle", {31'd0, irq}, 32'd0);
    wr(32'hC, 32'h9);
    wait_done("irq_done");
    check("irq_set", {31'd0, irq}, 32'd1);
    wr(32'hC, 32'hA);
    check("irq_w1c", {31'd0, irq}, 32'd0);
`endif
    check("sel_rule", sel_bad, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
